// File: rtl/prime_ram_arbiter_pkg.sv
// Shared widths and arbiter state encoding for the prime RAM arbiter.
package prime_ram_arbiter_pkg;

  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_ADDRESS_WIDTH = 10;
  localparam int BURST_CNT_W       = 4;

  typedef enum logic {
    GEN_PRI = 1'b0,
    PRT_PRI = 1'b1
  } arb_state_t;

endpackage

// File: rtl/prime_ram_arbiter_if.sv
// Generator, print and RAM-side signals of the arbiter; slave = arbiter, master = requesters/RAM.
interface prime_ram_arbiter_if
  import prime_ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) ();

  logic                     gen_req;
  logic                     gen_we;
  logic [ADDRESS_WIDTH-1:0] gen_addr;
  logic [DATA_WIDTH-1:0]    gen_wdata;
  logic                     gen_gnt;
  logic [DATA_WIDTH-1:0]    gen_rdata;
  logic                     gen_rvalid;

  logic                     prt_req;
  logic [ADDRESS_WIDTH-1:0] prt_addr;
  logic                     prt_gnt;
  logic [DATA_WIDTH-1:0]    prt_rdata;
  logic                     prt_rvalid;

  logic                     ram_we;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_wdata;
  logic [DATA_WIDTH-1:0]    ram_rdata;

  modport slave (
    input  gen_req, gen_we, gen_addr, gen_wdata, prt_req, prt_addr, ram_rdata,
    output gen_gnt, gen_rdata, gen_rvalid, prt_gnt, prt_rdata, prt_rvalid,
    output ram_we, ram_addr, ram_wdata
  );

  modport master (
    output gen_req, gen_we, gen_addr, gen_wdata, prt_req, prt_addr, ram_rdata,
    input  gen_gnt, gen_rdata, gen_rvalid, prt_gnt, prt_rdata, prt_rvalid,
    input  ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/prime_ram_arbiter.sv
// Two-port arbiter onto a single-port RAM: grants are combinational, read data is registered (latency 1).
// Requesters hold their request until granted; generator wins ties except after a MAX_GEN_BURST starvation run.
module prime_ram_arbiter
  import prime_ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int MAX_GEN_BURST = 4
) (
  input logic          Clk,
  input logic          Rst,
  prime_ram_arbiter_if.slave bus
);

  localparam logic [BURST_CNT_W-1:0] MAX_CNT = BURST_CNT_W'(MAX_GEN_BURST);

  arb_state_t               state_q, state_d;
  logic [BURST_CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                     gen_gnt, prt_gnt;
  logic [ADDRESS_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0]    gen_rdata_q, prt_rdata_q;
  logic                     gen_rvalid_q, prt_rvalid_q;

  always_comb begin
    gen_gnt     = 1'b0;
    prt_gnt     = 1'b0;
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    if (!Rst) begin
      if (state_q == GEN_PRI) begin
        if (bus.gen_req)      gen_gnt = 1'b1;
        else if (bus.prt_req) prt_gnt = 1'b1;

        // Only generator grants that leave print waiting count toward starvation.
        if (!bus.prt_req || prt_gnt) begin
          burst_cnt_d = '0;
        end else if (gen_gnt) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_d == MAX_CNT) state_d = PRT_PRI;
        end
      end else begin
        if (bus.prt_req)      prt_gnt = 1'b1;
        else if (bus.gen_req) gen_gnt = 1'b1;
        state_d     = GEN_PRI;
        burst_cnt_d = '0;
      end
    end
  end

  always_comb begin
    addr_mux = '0;
    if (gen_gnt)      addr_mux = bus.gen_addr;
    else if (prt_gnt) addr_mux = bus.prt_addr;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= GEN_PRI;
      burst_cnt_q  <= '0;
      gen_rvalid_q <= 1'b0;
      prt_rvalid_q <= 1'b0;
      gen_rdata_q  <= '0;
      prt_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      gen_rvalid_q <= gen_gnt && !bus.gen_we;
      prt_rvalid_q <= prt_gnt;
      if (gen_gnt && !bus.gen_we) gen_rdata_q <= bus.ram_rdata;
      if (prt_gnt)                prt_rdata_q <= bus.ram_rdata;
    end
  end

  assign bus.gen_gnt    = gen_gnt;
  assign bus.prt_gnt    = prt_gnt;
  assign bus.ram_addr   = addr_mux;
  assign bus.ram_we     = gen_gnt && bus.gen_we;
  assign bus.ram_wdata  = bus.gen_wdata;
  assign bus.gen_rdata  = gen_rdata_q;
  assign bus.gen_rvalid = gen_rvalid_q;
  assign bus.prt_rdata  = prt_rdata_q;
  assign bus.prt_rvalid = prt_rvalid_q;

  gnt_exclusive: assert property (@(posedge Clk) !(gen_gnt && prt_gnt));
  we_needs_gen:  assert property (@(posedge Clk) bus.ram_we |-> gen_gnt);

endmodule

// File: tb/tb_prime_ram_arbiter.sv
// Directed bench for prime_ram_arbiter with a behavioural async-read / sync-write RAM.
module tb_prime_ram_arbiter;
  import prime_ram_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  prime_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  prime_ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_GEN_BURST(4)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.ram_rdata = mem[bus.ram_addr];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic gr, input logic gw, input logic [AW-1:0] ga,
                       input logic [DW-1:0] gd, input logic pr, input logic [AW-1:0] pa);
    bus.gen_req   = gr;
    bus.gen_we    = gw;
    bus.gen_addr  = ga;
    bus.gen_wdata = gd;
    bus.prt_req   = pr;
    bus.prt_addr  = pa;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      chk("gnt_exclusive", 32'(bus.gen_gnt & bus.prt_gnt), 32'd0);
      chk("we_implies_gen", 32'(bus.ram_we & ~bus.gen_gnt), 32'd0);
    end
  end

  typedef struct {
    logic          gr, gw;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    logic          pr;
    logic [AW-1:0] pa;
    logic          e_gg, e_pg, e_we;
    logic [AW-1:0] e_ra;
    logic          e_grv;
    logic [DW-1:0] e_grd;
    logic          e_prv;
    logic [DW-1:0] e_prd;
  } vec_t;

  vec_t vec [10];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //        gr gw ga  gd       pr pa   gg pg we ra   grv grd      prv prd
    vec[0] = '{1, 1, 5, 16'd11,  0, 0,   1, 0, 1, 5,   0, 16'd0,    0, 16'd0};
    vec[1] = '{0, 0, 0, 16'd0,   1, 5,   0, 1, 0, 5,   0, 16'd0,    0, 16'd0};
    vec[2] = '{0, 0, 0, 16'd0,   0, 0,   0, 0, 0, 0,   0, 16'd0,    1, 16'd11};
    vec[3] = '{1, 0, 5, 16'd0,   0, 0,   1, 0, 0, 5,   0, 16'd0,    0, 16'd11};
    vec[4] = '{0, 0, 0, 16'd0,   0, 0,   0, 0, 0, 0,   1, 16'd11,   0, 16'd11};
    vec[5] = '{1, 1, 7, 16'h1234,0, 0,   1, 0, 1, 7,   0, 16'd11,   0, 16'd11};
    vec[6] = '{1, 0, 7, 16'd0,   0, 0,   1, 0, 0, 7,   0, 16'd11,   0, 16'd11};
    vec[7] = '{0, 0, 0, 16'd0,   1, 7,   0, 1, 0, 7,   1, 16'h1234, 0, 16'd11};
    vec[8] = '{1, 1, 9, 16'h55,  1, 7,   1, 0, 1, 9,   0, 16'h1234, 1, 16'h1234};
    vec[9] = '{0, 0, 0, 16'd0,   0, 0,   0, 0, 0, 0,   0, 16'h1234, 0, 16'h1234};

    // Reset with both requesters already asserting: nothing may be granted.
    rst = 1'b1;
    drive(1, 0, 10'd1, 16'd0, 1, 10'd2);
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rst_gen_gnt", 32'(bus.gen_gnt), 0);
    chk("rst_prt_gnt", 32'(bus.prt_gnt), 0);
    chk("rst_ram_we", 32'(bus.ram_we), 0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 0);
    chk("rst_gen_rvalid", 32'(bus.gen_rvalid), 0);
    chk("rst_prt_rvalid", 32'(bus.prt_rvalid), 0);
    chk("rst_gen_rdata", 32'(bus.gen_rdata), 0);
    chk("rst_prt_rdata", 32'(bus.prt_rdata), 0);
    chk("rst_state", 32'(dut.state_q), 32'(GEN_PRI));
    chk("rst_cnt", 32'(dut.burst_cnt_q), 0);

    // Continuous contention: G,G,G,G,P repeating.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk($sformatf("burst_gen_gnt[%0d]", i), 32'(bus.gen_gnt), 32'(i % 5 != 4));
      chk($sformatf("burst_prt_gnt[%0d]", i), 32'(bus.prt_gnt), 32'(i % 5 == 4));
      @(negedge clk);
      if (i == 0) chk("first_tie_cnt", 32'(dut.burst_cnt_q), 1);
      if (i == 3) chk("burst_state_prt", 32'(dut.state_q), 32'(PRT_PRI));
      if (i == 4) chk("burst_state_gen", 32'(dut.state_q), 32'(GEN_PRI));
    end
    drive(0, 0, 10'd0, 16'd0, 0, 10'd0);

    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      drive(vec[v].gr, vec[v].gw, vec[v].ga, vec[v].gd, vec[v].pr, vec[v].pa);
      #2;
      chk($sformatf("v%0d_gen_gnt", v), 32'(bus.gen_gnt), 32'(vec[v].e_gg));
      chk($sformatf("v%0d_prt_gnt", v), 32'(bus.prt_gnt), 32'(vec[v].e_pg));
      chk($sformatf("v%0d_ram_we", v), 32'(bus.ram_we), 32'(vec[v].e_we));
      chk($sformatf("v%0d_ram_addr", v), 32'(bus.ram_addr), 32'(vec[v].e_ra));
      chk($sformatf("v%0d_gen_rvalid", v), 32'(bus.gen_rvalid), 32'(vec[v].e_grv));
      chk($sformatf("v%0d_gen_rdata", v), 32'(bus.gen_rdata), 32'(vec[v].e_grd));
      chk($sformatf("v%0d_prt_rvalid", v), 32'(bus.prt_rvalid), 32'(vec[v].e_prv));
      chk($sformatf("v%0d_prt_rdata", v), 32'(bus.prt_rdata), 32'(vec[v].e_prd));
    end

    // Print drops its request while holding priority: generator gets the slot.
    @(negedge clk);
    drive(1, 0, 10'd3, 16'd0, 1, 10'd4);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("drop_gen_gnt[%0d]", k), 32'(bus.gen_gnt), 1);
      @(negedge clk);
    end
    chk("drop_state_prt", 32'(dut.state_q), 32'(PRT_PRI));
    bus.prt_req = 1'b0;
    #2;
    chk("drop_gen_wins", 32'(bus.gen_gnt), 1);
    chk("drop_prt_gnt", 32'(bus.prt_gnt), 0);
    @(negedge clk);
    chk("drop_state_gen", 32'(dut.state_q), 32'(GEN_PRI));
    chk("drop_cnt", 32'(dut.burst_cnt_q), 0);

    // Reset lands on a print read that would otherwise be granted.
    drive(0, 0, 10'd0, 16'd0, 1, 10'd7);
    rst = 1'b1;
    #2;
    chk("rstrd_prt_gnt", 32'(bus.prt_gnt), 0);
    chk("rstrd_ram_addr", 32'(bus.ram_addr), 0);
    @(negedge clk);
    chk("rstrd_prt_rvalid", 32'(bus.prt_rvalid), 0);
    chk("rstrd_prt_rdata", 32'(bus.prt_rdata), 0);
    chk("rstrd_state", 32'(dut.state_q), 32'(GEN_PRI));

    // A write presented during reset must not reach the RAM.
    drive(1, 1, 10'd3, 16'hDEAD, 0, 10'd0);
    #2;
    chk("rstwr_ram_we", 32'(bus.ram_we), 0);
    chk("rstwr_gen_gnt", 32'(bus.gen_gnt), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 10'd0, 16'd2, 0, 10'd0);
    #2;
    chk("wr0_gen_gnt", 32'(bus.gen_gnt), 1);
    chk("wr0_ram_we", 32'(bus.ram_we), 1);
    @(negedge clk);
    chk("wr0_mem", 32'(mem[0]), 2);
    chk("rstwr_mem_untouched", 32'(mem[3]), 0);
    drive(1, 0, 10'd0, 16'd0, 0, 10'd0);
    #2;
    chk("rd0_gen_gnt", 32'(bus.gen_gnt), 1);
    @(negedge clk);
    chk("rd0_gen_rvalid", 32'(bus.gen_rvalid), 1);
    chk("rd0_gen_rdata", 32'(bus.gen_rdata), 2);
    drive(0, 0, 10'd0, 16'd0, 0, 10'd0);
    @(negedge clk);
    chk("rd0_rvalid_pulse", 32'(bus.gen_rvalid), 0);
    chk("rd0_rdata_hold", 32'(bus.gen_rdata), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
